piece_redraw_seq: RTL

PIECE_REDRAW_SEQ -- requirements
Module: piece_redraw_seq

---
 rtl/piece_redraw_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/piece_redraw_seq.sv
// Erase-old / draw-new / full-clear cell painting sequencer driving a one-command painter.
// Kicks one live cell at a time, only while busy=0; waits for done; requests arriving mid-pass queue one-deep per type.
module piece_redraw_seq #(
  parameter int NCELLS       = 4,
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int CELL_W       = 24,
  parameter int CELL_H       = 24,
  parameter int SKIP_OVERLAP = 1,
  parameter int COLOR_W      = 9
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NCELLS*4-1:0] cur_cx,
  input  logic [NCELLS*5-1:0] cur_cy,
  input  logic                redraw_req,
  input  logic                clear_req,
  input  logic [COLOR_W-1:0]  piece_color,
  input  logic [COLOR_W-1:0]  bg_color,
  output logic                kick,
  output logic [9:0]          x0,
  output logic [8:0]          y0,
  output logic [COLOR_W-1:0]  paint_color,
  input  logic                busy,
  input  logic                done,
  output logic                seq_busy,
  output logic                frame_done
);
  localparam int IW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ERASE, DRAW, COMMIT} state_t;
  typedef enum logic {ISSUE, WAIT} phase_t;

  state_t state, state_n;
  phase_t phase, phase_n;

  logic [IW-1:0]       idx;
  logic [3:0]          clr_x;
  logic [4:0]          clr_y;
  logic [NCELLS*4-1:0] sh_cx, pv_cx;
  logic [NCELLS*5-1:0] sh_cy, pv_cy;
  logic                pend_clr, pend_rd, rst_d;
  logic                arm, snap, take, step, last, commit;
  logic [3:0]          cell_cx;
  logic [4:0]          cell_cy;
  logic                cell_live, overlap;

  // rst_d marks the first cycle out of reset, which launches the initial draw-only pass
  assign arm      = rst_d & ~reset;
  assign seq_busy = (state != IDLE) | pend_clr | pend_rd | arm;

  always_comb begin
    cell_cx = '0;
    cell_cy = '0;
    overlap = 1'b0;
    last    = 1'b0;
    case (state)
      CLEAR: begin
        cell_cx = clr_x;
        cell_cy = clr_y;
        last    = (32'(clr_x) == COLS - 1) && (32'(clr_y) == ROWS - 1);
      end
      ERASE: begin
        cell_cx = pv_cx[4*idx +: 4];
        cell_cy = pv_cy[5*idx +: 5];
        last    = (32'(idx) == NCELLS - 1);
      end
      default: begin
        cell_cx = sh_cx[4*idx +: 4];
        cell_cy = sh_cy[5*idx +: 5];
        last    = (32'(idx) == NCELLS - 1);
      end
    endcase
    if (SKIP_OVERLAP != 0 && state == ERASE) begin
      for (int j = 0; j < NCELLS; j++) begin
        if (cell_cx == sh_cx[4*j +: 4] && cell_cy == sh_cy[5*j +: 5])
          overlap = 1'b1;
      end
    end
    cell_live = (32'(cell_cx) < COLS) && (32'(cell_cy) < ROWS) && !overlap;
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    kick        = 1'b0;
    snap        = 1'b0;
    take        = 1'b0;
    step        = 1'b0;
    commit      = 1'b0;
    frame_done  = 1'b0;
    x0          = '0;
    y0          = '0;
    paint_color = '0;
    case (state)
      IDLE: begin
        phase_n = ISSUE;
        if (arm) begin
          snap    = 1'b1;
          state_n = DRAW;
        end else if (pend_clr || clear_req) begin
          snap    = 1'b1;
          take    = 1'b1;
          state_n = CLEAR;
        end else if (pend_rd || redraw_req) begin
          snap    = 1'b1;
          take    = 1'b1;
          state_n = ERASE;
        end
      end
      CLEAR, ERASE, DRAW: begin
        x0          = 10'(32'(cell_cx) * CELL_W);
        y0          = 9'(32'(cell_cy) * CELL_H);
        paint_color = (state == DRAW) ? piece_color : bg_color;
        if (phase == ISSUE) begin
          if (!cell_live) begin
            step = 1'b1;
          end else if (!busy) begin
            kick    = 1'b1;
            phase_n = WAIT;
          end
        end else if (done) begin
          step    = 1'b1;
          phase_n = ISSUE;
        end
        if (step && last)
          state_n = (state == DRAW) ? COMMIT : DRAW;
      end
      COMMIT: begin
        phase_n    = ISSUE;
        commit     = 1'b1;
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= ISSUE;
      idx      <= '0;
      clr_x    <= '0;
      clr_y    <= '0;
      sh_cx    <= '0;
      sh_cy    <= '0;
      pv_cx    <= '0;
      pv_cy    <= {NCELLS{5'd31}};
      pend_clr <= 1'b0;
      pend_rd  <= 1'b0;
      rst_d    <= 1'b1;
    end else begin
      state <= state_n;
      phase <= phase_n;
      rst_d <= 1'b0;
      if (state_n != state) begin
        idx   <= '0;
        clr_x <= '0;
        clr_y <= '0;
      end else if (step) begin
        if (state == CLEAR) begin
          if (32'(clr_x) == COLS - 1) begin
            clr_x <= '0;
            clr_y <= clr_y + 5'd1;
          end else begin
            clr_x <= clr_x + 4'd1;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (snap) begin
        sh_cx <= cur_cx;
        sh_cy <= cur_cy;
      end
      if (commit) begin
        pv_cx <= sh_cx;
        pv_cy <= sh_cy;
      end
      // requests seen in the cycle a pass starts are absorbed by that pass
      if (take) begin
        pend_clr <= 1'b0;
        pend_rd  <= 1'b0;
      end else if (clear_req) begin
        pend_clr <= 1'b1;
      end else if (redraw_req) begin
        pend_rd <= 1'b1;
      end
    end
  end
endmodule
